// File: rtl/saw_pkg.sv
// Shared definitions for the 8-bit bus machine control path.
// Holds:
//   - opcode encodings (IR[7:4]);
//   - ALU select words, ordered {xor_not, add_sub, alu1_or, alu0_and};
//   - the sequencer state enum, whose values are the t_state debug codes;
//   - the control word struct driven by the decoder;
//   - a helper that maps a binary ALU opcode to its select word.
package saw_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_STA = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  // Enum values double as the t_state debug encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       ir_out;
    logic       ram_out;
    logic       acc_out;
    logic       alu_out;
    logic       pc_inc;
    logic       mar_in;
    logic       ir_in;
    logic       ram_in;
    logic       acc_in;
    logic       b_in;
    logic       out_in;
    logic [3:0] alu_sel;
  } ctrl_t;

  function automatic logic [3:0] alu_sel_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: (state, opcode) -> control word.
// Ports:
//   state    in   current sequencer state
//   opcode   in   IR[7:4]; only looked at in T3..T5
//   ctrl     out  bus-driver enables, load strobes, ALU select
//   last     out  this cycle retires the instruction
//   halt_req out  retiring instruction is HLT (next state HALT)
module ctrl_decode
  import saw_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_t      ctrl,
  output logic       last,
  output logic       halt_req
);

  always_comb begin
    ctrl     = '0;
    last     = 1'b0;
    halt_req = 1'b0;
    case (state)
      // Fetch never depends on opcode, so an unknown IR during fetch
      // cannot disturb the strobes.
      ST_T1: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      ST_T2: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end
      ST_T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end
          OP_NOT: begin
            ctrl.alu_out = 1'b1;
            ctrl.acc_in  = 1'b1;
            ctrl.alu_sel = ALU_NOT;
            last         = 1'b1;
          end
          OP_OUT: begin
            ctrl.acc_out = 1'b1;
            ctrl.out_in  = 1'b1;
            last         = 1'b1;
          end
          OP_HLT: begin
            last     = 1'b1;
            halt_req = 1'b1;
          end
          default: last = 1'b1;  // 0x8..0xD are single-cycle NOPs
        endcase
      end
      ST_T4: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.acc_in  = 1'b1;
            last         = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
          end
          OP_STA: begin
            ctrl.acc_out = 1'b1;
            ctrl.ram_in  = 1'b1;
            last         = 1'b1;
          end
          // Only reachable if IR changed mid-instruction; retire so the
          // sequencer always returns to fetch.
          default: last = 1'b1;
        endcase
      end
      ST_T5: begin
        last = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl.alu_out = 1'b1;
            ctrl.acc_in  = 1'b1;
            ctrl.alu_sel = alu_sel_of(opcode);
          end
          default: ;
        endcase
      end
      default: ;  // IDLE and HALT drive nothing
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer for the 8-bit bus machine. Steps IDLE -> T1..T5 per
// instruction and drives every bus-driver enable, load strobe and ALU
// select line. It is the sole source of bus-driver enables.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   run               1 = keep executing, 0 = park at instruction boundary
//   opcode            IR[7:4]
//   pc_out..alu_out   bus-driver enables (at most one high)
//   pc_inc..out_in    load / increment strobes
//   add_sub, alu0_and, alu1_or, xor_not   ALU select
//   instr_done        pulse on the last cycle of each instruction
//   halted            high in HALT
//   t_state           debug state code (0 IDLE, 1..5 T1..T5, 7 HALT)
module control_sequencer
  import saw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_out,
  output logic       ir_out,
  output logic       ram_out,
  output logic       acc_out,
  output logic       alu_out,
  output logic       pc_inc,
  output logic       mar_in,
  output logic       ir_in,
  output logic       ram_in,
  output logic       acc_in,
  output logic       b_in,
  output logic       out_in,
  output logic       add_sub,
  output logic       alu0_and,
  output logic       alu1_or,
  output logic       xor_not,
  output logic       instr_done,
  output logic       halted,
  output logic [2:0] t_state
);

  state_t state;
  ctrl_t  ctrl;
  logic   last;
  logic   halt_req;

  ctrl_decode u_decode (
    .state    (state),
    .opcode   (opcode),
    .ctrl     (ctrl),
    .last     (last),
    .halt_req (halt_req)
  );

  // run is only consulted in IDLE and on the retiring cycle, so dropping
  // it mid-instruction lets the instruction finish before parking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (run) state <= ST_T1;
        ST_T1:   state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3, ST_T4, ST_T5: begin
          if (last) begin
            if (halt_req)  state <= ST_HALT;
            else if (run)  state <= ST_T1;
            else           state <= ST_IDLE;
          end else if (state == ST_T3) begin
            state <= ST_T4;
          end else begin
            state <= ST_T5;
          end
        end
        ST_HALT: state <= ST_HALT;  // only reset leaves HALT
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pc_out     = ctrl.pc_out;
  assign ir_out     = ctrl.ir_out;
  assign ram_out    = ctrl.ram_out;
  assign acc_out    = ctrl.acc_out;
  assign alu_out    = ctrl.alu_out;
  assign pc_inc     = ctrl.pc_inc;
  assign mar_in     = ctrl.mar_in;
  assign ir_in      = ctrl.ir_in;
  assign ram_in     = ctrl.ram_in;
  assign acc_in     = ctrl.acc_in;
  assign b_in       = ctrl.b_in;
  assign out_in     = ctrl.out_in;
  assign xor_not    = ctrl.alu_sel[3];
  assign add_sub    = ctrl.alu_sel[2];
  assign alu1_or    = ctrl.alu_sel[1];
  assign alu0_and   = ctrl.alu_sel[0];
  assign instr_done = last;
  assign halted     = (state == ST_HALT);
  assign t_state    = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction pushes its
// expected per-cycle output words, which are popped and compared as the
// sequencer steps through them.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run;
  logic [3:0] opcode;
  logic pc_out, ir_out, ram_out, acc_out, alu_out;
  logic pc_inc, mar_in, ir_in, ram_in, acc_in, b_in, out_in;
  logic add_sub, alu0_and, alu1_or, xor_not, instr_done, halted;
  logic [2:0] t_state;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .pc_out(pc_out), .ir_out(ir_out), .ram_out(ram_out), .acc_out(acc_out),
    .alu_out(alu_out), .pc_inc(pc_inc), .mar_in(mar_in), .ir_in(ir_in),
    .ram_in(ram_in), .acc_in(acc_in), .b_in(b_in), .out_in(out_in),
    .add_sub(add_sub), .alu0_and(alu0_and), .alu1_or(alu1_or),
    .xor_not(xor_not), .instr_done(instr_done), .halted(halted),
    .t_state(t_state)
  );

  always #5 clk = ~clk;

  // Observed word: [20:18] t_state, [17:6] enables/strobes,
  // [5:2] {xor_not,add_sub,alu1_or,alu0_and}, [1] instr_done, [0] halted
  localparam logic [20:0] PC_OUT  = 21'd1 << 17;
  localparam logic [20:0] IR_OUT  = 21'd1 << 16;
  localparam logic [20:0] RAM_OUT = 21'd1 << 15;
  localparam logic [20:0] ACC_OUT = 21'd1 << 14;
  localparam logic [20:0] ALU_OUT = 21'd1 << 13;
  localparam logic [20:0] PC_INC  = 21'd1 << 12;
  localparam logic [20:0] MAR_IN  = 21'd1 << 11;
  localparam logic [20:0] IR_IN   = 21'd1 << 10;
  localparam logic [20:0] RAM_IN  = 21'd1 << 9;
  localparam logic [20:0] ACC_IN  = 21'd1 << 8;
  localparam logic [20:0] B_IN    = 21'd1 << 7;
  localparam logic [20:0] OUT_IN  = 21'd1 << 6;
  localparam logic [20:0] DONE    = 21'd1 << 1;
  localparam logic [20:0] HALTED  = 21'd1;

  int tests = 0, fails = 0;
  int done_cnt = 0, mon_viol = 0;
  bit mon_en = 1'b0;
  logic [20:0] exp_q[$];

  function automatic logic [20:0] ts(input int t);
    return 21'(t) << 18;
  endfunction

  function automatic logic [20:0] sel(input logic [3:0] s);
    return 21'(s) << 2;
  endfunction

  function automatic logic [20:0] obs();
    return {t_state, pc_out, ir_out, ram_out, acc_out, alu_out, pc_inc,
            mar_in, ir_in, ram_in, acc_in, b_in, out_in,
            xor_not, add_sub, alu1_or, alu0_and, instr_done, halted};
  endfunction

  // Invariant monitor for the random phase.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (!$onehot0({pc_out, ir_out, ram_out, acc_out, alu_out})) mon_viol++;
      if (acc_in && ram_in) mon_viol++;
      if (instr_done) done_cnt++;
    end
  end

  // Expected cycle-by-cycle words for one instruction, fetch included.
  task automatic push_instr(input logic [3:0] op);
    logic [3:0] s;
    exp_q.push_back(ts(1) | PC_OUT | MAR_IN);
    exp_q.push_back(ts(2) | RAM_OUT | IR_IN | PC_INC);
    case (op)
      4'h0: begin
        exp_q.push_back(ts(3) | IR_OUT | MAR_IN);
        exp_q.push_back(ts(4) | RAM_OUT | ACC_IN | DONE);
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        case (op)
          4'h1:    s = 4'b0000;
          4'h2:    s = 4'b0100;
          4'h3:    s = 4'b0001;
          4'h4:    s = 4'b0010;
          default: s = 4'b0011;
        endcase
        exp_q.push_back(ts(3) | IR_OUT | MAR_IN);
        exp_q.push_back(ts(4) | RAM_OUT | B_IN);
        exp_q.push_back(ts(5) | ALU_OUT | ACC_IN | sel(s) | DONE);
      end
      4'h6: exp_q.push_back(ts(3) | ALU_OUT | ACC_IN | sel(4'b1011) | DONE);
      4'h7: begin
        exp_q.push_back(ts(3) | IR_OUT | MAR_IN);
        exp_q.push_back(ts(4) | ACC_OUT | RAM_IN | DONE);
      end
      4'hE:    exp_q.push_back(ts(3) | ACC_OUT | OUT_IN | DONE);
      default: exp_q.push_back(ts(3) | DONE);  // NOPs and HLT
    endcase
  endtask

  // Precondition: the next rising edge enters T1. opcode is X during T1/T2
  // and valid from T3. run is set to keep_run on the retiring cycle; with
  // wiggle, run toggles randomly on the cycles where it must be ignored.
  task automatic play(input logic [3:0] op, input bit keep_run,
                      input int drop_at, input bit wiggle,
                      input string name, output int len);
    int idx = 0;
    logic [20:0] e, o;
    push_instr(op);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      o = obs();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s op=%h cyc%0d: got %h want %h", name, op, idx, o, e);
      end
      if (idx == 0) opcode = 4'bxxxx;
      if (idx == 1) opcode = op;
      if (wiggle) run = 1'($urandom_range(0, 1));
      if (idx == drop_at) run = 1'b0;
      if (exp_q.size() == 0) run = keep_run;
      idx++;
    end
    len = idx;
  endtask

  task automatic test_reset();
    bit found = 1'b0;
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0;
    #2;
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL reset_init: got %h want 0", obs()); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; opcode = 4'h1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (t_state == 3'd4) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL reset_reach_t4: got t_state %0d want 4", t_state); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL reset_async: got %h want 0", obs()); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== 21'd0) begin fails++; $display("FAIL reset_idle%0d: got %h want 0", i, obs()); end
    end
  endtask

  task automatic test_add();
    int len;
    run = 1'b1; opcode = 4'h1;
    play(4'h1, 1'b1, -1, 1'b0, "add", len);
    play(4'h8, 1'b0, -1, 1'b0, "add_next_t1", len);
    @(negedge clk);
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL add_park: got %h want 0", obs()); end
  endtask

  task automatic test_sweep();
    logic [3:0] ops [5] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    int         lens[5] = '{5, 5, 5, 5, 3};
    int len;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      play(ops[i], i < 4, -1, 1'b0, "sweep", len);
      tests++;
      if (len !== lens[i]) begin
        fails++; $display("FAIL sweep_len op=%h: got %0d want %0d", ops[i], len, lens[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL sweep_park: got %h want 0", obs()); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [5] = '{4'h0, 4'h7, 4'hE, 4'hA, 4'hD};
    int         lens[5] = '{4, 4, 3, 3, 3};
    int len;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      play(ops[i], i < 4, -1, 1'b0, "b2b", len);
      tests++;
      if (len !== lens[i]) begin
        fails++; $display("FAIL b2b_len op=%h: got %0d want %0d", ops[i], len, lens[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL b2b_park: got %h want 0", obs()); end
  endtask

  task automatic test_run_drop();
    int len;
    run = 1'b1;
    play(4'h0, 1'b0, 2, 1'b0, "lda_drop", len);
    @(negedge clk);
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL lda_park: got %h want 0", obs()); end
    run = 1'b1;
    play(4'hE, 1'b0, -1, 1'b0, "restart", len);
    @(negedge clk);
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL restart_park: got %h want 0", obs()); end
  endtask

  task automatic test_halt();
    int len;
    run = 1'b1;
    play(4'hF, 1'b1, -1, 1'b0, "hlt", len);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== (ts(7) | HALTED)) begin
        fails++; $display("FAIL halt_hold%0d: got %h want %h", i, obs(), ts(7) | HALTED);
      end
      run = ~run;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL halt_reset: got %h want 0", obs()); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    @(negedge clk);
    tests++;
    if (obs() !== 21'd0) begin fails++; $display("FAIL halt_idle: got %h want 0", obs()); end
  endtask

  task automatic test_random();
    int cyc = 0, n_instr = 0, len;
    bit keep;
    logic [3:0] op;
    done_cnt = 0; mon_viol = 0;
    mon_en = 1'b1;
    run = 1'b1;
    while (cyc < 10000) begin
      op   = 4'($urandom_range(0, 14));
      keep = ($urandom_range(0, 7) != 0);
      play(op, keep, -1, 1'b1, "rand", len);
      n_instr++;
      cyc += len;
      if (!keep) begin
        @(negedge clk);
        tests++;
        if (obs() !== 21'd0) begin fails++; $display("FAIL rand_park: got %h want 0", obs()); end
        run = 1'b1;
        cyc++;
      end
    end
    play(4'h9, 1'b0, -1, 1'b0, "rand_end", len);
    n_instr++;
    @(negedge clk);
    mon_en = 1'b0;
    tests++;
    if (done_cnt !== n_instr) begin
      fails++; $display("FAIL rand_done_count: got %0d want %0d", done_cnt, n_instr);
    end
    tests++;
    if (mon_viol !== 0) begin
      fails++; $display("FAIL rand_invariants: got %0d violations want 0", mon_viol);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sweep();
    test_back_to_back();
    test_run_drop();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
